// File: rtl/adc_cfg_sequencer.sv
// ADC serial-register configuration sequencer: 8-entry shadow file, batch load and host single access.
// Optional per-entry readback verification is enabled by `ADC_CFG_READBACK_EN.
module adc_cfg_sequencer #(
  parameter logic [71:0] DEFAULT_CFG = 72'h0,
  parameter bit          AUTO_LOAD   = 1'b1,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shd_we,
  input  logic [2:0] shd_addr,
  input  logic [8:0] shd_wdata,
  input  logic       cfg_load,
  input  logic       host_req,
  input  logic       host_rw,
  input  logic [2:0] host_addr,
  input  logic [8:0] host_wdata,
  output logic       host_ack,
  output logic [8:0] host_rdata,
  output logic       ser_start,
  output logic       ser_rw,
  output logic [2:0] ser_addr,
  output logic [8:0] ser_wdata,
  input  logic       ser_busy,
  input  logic [8:0] ser_rdata,
  output logic       busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [7:0] err_mask
);
  localparam int unsigned NENT = 8;
  localparam int unsigned TW   = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_NEXT
`ifdef ADC_CFG_READBACK_EN
    , S_VERIFY
`endif
  } state_t;

  state_t        state;
  logic [8:0]    shadow [NENT];
  logic [2:0]    idx;
  logic          is_batch;
  logic          cfg_pend;
  logic          h_rw;
  logic [2:0]    h_addr;
  logic [8:0]    h_wdata;
  logic [TW-1:0] tmo;
  logic          tmo_exp_c;
`ifdef ADC_CFG_READBACK_EN
  logic          vphase;
`endif

  // A wait state has used its whole budget without seeing the awaited ser_busy level.
  assign tmo_exp_c = (tmo == '0) &&
                     (((state == S_WAIT_HI) && !ser_busy) || ((state == S_WAIT_LO) && ser_busy));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      is_batch   <= 1'b0;
      cfg_pend   <= AUTO_LOAD;
      h_rw       <= 1'b0;
      h_addr     <= '0;
      h_wdata    <= '0;
      tmo        <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      ser_start  <= 1'b0;
      ser_rw     <= 1'b0;
      ser_addr   <= '0;
      ser_wdata  <= '0;
      busy       <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
      err_mask   <= '0;
`ifdef ADC_CFG_READBACK_EN
      vphase     <= 1'b0;
`endif
      for (int i = 0; i < NENT; i++) shadow[i] <= DEFAULT_CFG[9*i +: 9];
    end else begin
      host_ack <= 1'b0;
      if (cfg_load) cfg_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          // Batch has priority; a host request is not re-accepted during its own ack cycle.
          if (cfg_pend || cfg_load) begin
            state    <= S_ISSUE;
            busy     <= 1'b1;
            is_batch <= 1'b1;
            idx      <= '0;
            cfg_pend <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            err_mask <= '0;
`ifdef ADC_CFG_READBACK_EN
            vphase   <= 1'b0;
`endif
          end else if (host_req && !host_ack) begin
            state    <= S_ISSUE;
            busy     <= 1'b1;
            is_batch <= 1'b0;
            h_rw     <= host_rw;
            h_addr   <= host_addr;
            h_wdata  <= host_wdata;
          end else begin
            busy <= 1'b0;
          end
        end
        S_ISSUE: begin
          ser_start <= 1'b1;
`ifdef ADC_CFG_READBACK_EN
          ser_rw    <= is_batch ? ~vphase : h_rw;
`else
          ser_rw    <= is_batch ? 1'b1 : h_rw;
`endif
          ser_addr  <= is_batch ? idx : h_addr;
          ser_wdata <= is_batch ? shadow[idx] : h_wdata;
          tmo       <= TW'(TIMEOUT - 1);
          state     <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (ser_busy) begin
            ser_start <= 1'b0;
            tmo       <= TW'(TIMEOUT - 1);
            state     <= S_WAIT_LO;
          end else begin
            tmo <= tmo - TW'(1);
          end
        end
        S_WAIT_LO: begin
          if (!ser_busy) begin
            if (is_batch) begin
`ifdef ADC_CFG_READBACK_EN
              if (!vphase) begin
                state <= S_VERIFY;
              end else begin
                if (ser_rdata != shadow[idx]) begin
                  err_mask[idx] <= 1'b1;
                  cfg_err       <= 1'b1;
                end
                vphase <= 1'b0;
                state  <= S_NEXT;
              end
`else
              state <= S_NEXT;
`endif
            end else begin
              host_ack <= 1'b1;
              if (h_rw) shadow[h_addr] <= h_wdata;
              else      host_rdata     <= ser_rdata;
              state <= S_IDLE;
            end
          end else begin
            tmo <= tmo - TW'(1);
          end
        end
        S_NEXT: begin
          if (idx == 3'd7) begin
            cfg_done <= ~cfg_err;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            idx   <= idx + 3'd1;
            state <= S_ISSUE;
          end
        end
`ifdef ADC_CFG_READBACK_EN
        S_VERIFY: begin
          vphase <= 1'b1;
          state  <= S_ISSUE;
        end
`endif
        default: state <= S_IDLE;
      endcase

      // Abort overrides whatever the wait state decided this cycle.
      if (tmo_exp_c) begin
        ser_start <= 1'b0;
        state     <= S_IDLE;
        if (is_batch) begin
          cfg_err  <= 1'b1;
          cfg_done <= 1'b0;
          busy     <= 1'b0;
        end else begin
          host_ack   <= 1'b1;
          host_rdata <= 9'h1FF;
        end
      end

      if (shd_we) shadow[shd_addr] <= shd_wdata;
    end
  end

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Directed bench for adc_cfg_sequencer with a behavioural serial-engine model.
module tb_adc_cfg_sequencer;
  localparam int unsigned BUSY_LEN = 20;
`ifdef ADC_CFG_READBACK_EN
  localparam int FPB = 2;
`else
  localparam int FPB = 1;
`endif
  localparam logic [71:0] DCFG = {9'h017, 9'h016, 9'h015, 9'h014, 9'h013, 9'h012, 9'h011, 9'h010};

  typedef struct {logic rw; logic [2:0] addr; logic [8:0] data;} frame_t;
  typedef struct {logic rw; logic [2:0] addr; logic [8:0] wdata; bit frc; logic [8:0] exp_rdata;} hvec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic shd_we = 1'b0, cfg_load = 1'b0, host_req = 1'b0, host_rw = 1'b0;
  logic [2:0] shd_addr = '0, host_addr = '0;
  logic [8:0] shd_wdata = '0, host_wdata = '0;
  logic host_ack, ser_start, ser_rw, busy, cfg_done, cfg_err;
  logic [8:0] host_rdata, ser_wdata;
  logic [2:0] ser_addr;
  logic [7:0] err_mask;
  logic ser_busy = 1'b0;
  logic [8:0] ser_rdata = '0;

  logic t_zero1 = 1'b0;
  logic [2:0] t_zero3 = '0;
  logic [8:0] t_zero9 = '0;
  logic t_host_ack, t_ser_start, t_ser_rw, t_busy, t_cfg_done, t_cfg_err;
  logic [8:0] t_host_rdata, t_ser_wdata;
  logic [2:0] t_ser_addr;
  logic [7:0] t_err_mask;

  always #5 clk = ~clk;

  adc_cfg_sequencer #(.DEFAULT_CFG(DCFG), .AUTO_LOAD(1'b1), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .shd_we(shd_we), .shd_addr(shd_addr), .shd_wdata(shd_wdata),
    .cfg_load(cfg_load), .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .ser_start(ser_start), .ser_rw(ser_rw), .ser_addr(ser_addr), .ser_wdata(ser_wdata),
    .ser_busy(ser_busy), .ser_rdata(ser_rdata), .busy(busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .err_mask(err_mask));

  // Second instance whose engine never answers, for the timeout path.
  adc_cfg_sequencer #(.DEFAULT_CFG(DCFG), .AUTO_LOAD(1'b1), .TIMEOUT(16)) u_tmo (
    .clk(clk), .rst_n(rst_n), .shd_we(t_zero1), .shd_addr(t_zero3), .shd_wdata(t_zero9),
    .cfg_load(t_zero1), .host_req(t_zero1), .host_rw(t_zero1), .host_addr(t_zero3),
    .host_wdata(t_zero9), .host_ack(t_host_ack), .host_rdata(t_host_rdata),
    .ser_start(t_ser_start), .ser_rw(t_ser_rw), .ser_addr(t_ser_addr), .ser_wdata(t_ser_wdata),
    .ser_busy(t_zero1), .ser_rdata(t_zero9), .busy(t_busy), .cfg_done(t_cfg_done),
    .cfg_err(t_cfg_err), .err_mask(t_err_mask));

  // Serial engine model: busy for BUSY_LEN clocks per frame, keeps its own register image.
  logic [8:0] adc_regs [8];
  frame_t frames[$];
  bit eng_active = 1'b0;
  int eng_cnt = 0;
  frame_t eng_cur;
  time t_fall = 0;
  bit force_rd = 1'b0;
  bit corrupt_en = 1'b0;
  logic [2:0] corrupt_addr = '0;

  always @(negedge clk) begin
    if (eng_active) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_active = 1'b0;
        ser_busy = 1'b0;
        t_fall = $time;
        if (eng_cur.rw) adc_regs[eng_cur.addr] = eng_cur.data;
        else if (force_rd) ser_rdata = 9'h0AB;
        else ser_rdata = adc_regs[eng_cur.addr] ^
                         ((corrupt_en && eng_cur.addr == corrupt_addr) ? 9'h001 : 9'h000);
      end
    end else if (ser_start) begin
      eng_cur = '{ser_rw, ser_addr, ser_wdata};
      frames.push_back(eng_cur);
      eng_active = 1'b1;
      eng_cnt = BUSY_LEN;
      ser_busy = 1'b1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_frame(input string nm, input int idx, input logic rw,
                             input logic [2:0] a, input logic [8:0] d);
    if (idx >= frames.size()) check({nm, "_missing"}, 64'(frames.size()), 64'(idx + 1));
    else check(nm, 64'({frames[idx].rw, frames[idx].addr, frames[idx].data}), 64'({rw, a, d}));
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < 4000) begin
      @(negedge clk);
      n++;
      if (busy) quiet = 0; else quiet++;
    end
    check(nm, 64'(quiet >= 4), 64'(1));
  endtask

  task automatic pulse_load();
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hvec_t hv[6];
    int nf;
    int n;
    hv[0] = '{1'b0, 3'd5, 9'h000, 1'b1, 9'h0AB};
    hv[1] = '{1'b1, 3'd6, 9'h1C3, 1'b0, 9'h0AB};
    hv[2] = '{1'b0, 3'd6, 9'h000, 1'b0, 9'h1C3};
    hv[3] = '{1'b0, 3'd0, 9'h000, 1'b0, 9'h010};
    hv[4] = '{1'b1, 3'd7, 9'h000, 1'b0, 9'h010};
    hv[5] = '{1'b0, 3'd7, 9'h000, 1'b0, 9'h000};

    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({host_ack, host_rdata, ser_start, ser_rw, ser_addr, ser_wdata,
                              busy, cfg_done, cfg_err, err_mask}), 64'(0));
    check("rst_outputs_tmo", 64'({t_host_ack, t_host_rdata, t_ser_start, t_ser_rw, t_ser_addr,
                                  t_ser_wdata, t_busy, t_cfg_done, t_cfg_err, t_err_mask}), 64'(0));
    rst_n = 1'b1;

    // Timeout instance: WAIT_HI budget of 16 clocks.
    n = 0;
    while (!t_ser_start && n < 20) begin @(negedge clk); n++; end
    check("tmo_start_seen", 64'(t_ser_start), 64'(1));
    n = 0;
    while (t_ser_start && n < 100) begin n++; @(negedge clk); end
    check("tmo_start_width", 64'(n), 64'(16));
    check("tmo_cfg_err", 64'(t_cfg_err), 64'(1));
    check("tmo_cfg_done", 64'(t_cfg_done), 64'(0));
    check("tmo_busy", 64'(t_busy), 64'(0));

    // Auto-load batch after reset release.
    wait_idle("auto_idle");
    check("auto_done", 64'(cfg_done), 64'(1));
    check("auto_err", 64'(cfg_err), 64'(0));
    check("auto_mask", 64'(err_mask), 64'(0));
    check("auto_frames", 64'(frames.size()), 64'(8 * FPB));
    for (int i = 0; i < 8; i++) begin
      check_frame("auto_wr", i * FPB, 1'b1, 3'(i), 9'(16 + i));
      if (FPB == 2) check_frame("auto_rb", i * FPB + 1, 1'b0, 3'(i), 9'(16 + i));
    end

    // Host single accesses from the vector table.
    for (int i = 0; i < 6; i++) begin
      nf = frames.size();
      force_rd = hv[i].frc;
      host_rw = hv[i].rw;
      host_addr = hv[i].addr;
      host_wdata = hv[i].wdata;
      host_req = 1'b1;
      @(negedge clk);
      check("h_lat_busy", 64'(busy), 64'(1));
      check("h_lat_nostart", 64'(ser_start), 64'(0));
      @(negedge clk);
      check("h_lat_start", 64'(ser_start), 64'(1));
      n = 0;
      while (!host_ack && n < 200) begin @(negedge clk); n++; end
      check("h_ack", 64'(host_ack), 64'(1));
      check("h_ack_lat", 64'($time - t_fall), 64'(10));
      check("h_rdata", 64'(host_rdata), 64'(hv[i].exp_rdata));
      host_req = 1'b0;
      check("h_frames", 64'(frames.size() - nf), 64'(1));
      check_frame("h_frame", nf, hv[i].rw, hv[i].addr, hv[i].wdata);
      @(negedge clk);
      check("h_ack_pulse", 64'(host_ack), 64'(0));
      check("h_busy_drop", 64'(busy), 64'(0));
      check("h_rdata_hold", 64'(host_rdata), 64'(hv[i].exp_rdata));
    end
    force_rd = 1'b0;

    // Host write raised during a batch is served only after entry 7.
    nf = frames.size();
    pulse_load();
    host_rw = 1'b1; host_addr = 3'd2; host_wdata = 9'h155; host_req = 1'b1;
    n = 0;
    while (!host_ack && n < 3000) begin @(negedge clk); n++; end
    check("hb_ack", 64'(host_ack), 64'(1));
    host_req = 1'b0;
    check("hb_frames", 64'(frames.size() - nf), 64'(8 * FPB + 1));
    check_frame("hb_batch_a2", nf + 2 * FPB, 1'b1, 3'd2, 9'h012);
    check_frame("hb_host_last", nf + 8 * FPB, 1'b1, 3'd2, 9'h155);
    check("hb_done", 64'(cfg_done), 64'(1));
    wait_idle("hb_idle");
    nf = frames.size();
    pulse_load();
    wait_idle("reload_idle");
    check_frame("reload_a2", nf + 2 * FPB, 1'b1, 3'd2, 9'h155);
    check_frame("reload_a6", nf + 6 * FPB, 1'b1, 3'd6, 9'h1C3);

    // Shadow write to an already-sent entry plus two cfg_load pulses during a batch.
    nf = frames.size();
    pulse_load();
    n = 0;
    while (frames.size() < nf + FPB + 1 && n < 500) begin @(negedge clk); n++; end
    shd_we = 1'b1; shd_addr = 3'd0; shd_wdata = 9'h1AA; cfg_load = 1'b1;
    @(negedge clk);
    shd_we = 1'b0; cfg_load = 1'b0;
    @(negedge clk);
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    wait_idle("dbl_idle");
    check("dbl_frames", 64'(frames.size() - nf), 64'(16 * FPB));
    check_frame("dbl_b1_a0", nf, 1'b1, 3'd0, 9'h010);
    check_frame("dbl_b2_a0", nf + 8 * FPB, 1'b1, 3'd0, 9'h1AA);
    check("dbl_done", 64'(cfg_done), 64'(1));
    check("dbl_err", 64'(cfg_err), 64'(0));

`ifdef ADC_CFG_READBACK_EN
    nf = frames.size();
    corrupt_addr = 3'd3;
    corrupt_en = 1'b1;
    pulse_load();
    wait_idle("rb_idle");
    corrupt_en = 1'b0;
    check("rb_mask", 64'(err_mask), 64'(8'h08));
    check("rb_err", 64'(cfg_err), 64'(1));
    check("rb_done", 64'(cfg_done), 64'(0));
    check("rb_frames", 64'(frames.size() - nf), 64'(16));
    check_frame("rb_read_a3", nf + 7, 1'b0, 3'd3, 9'h013);
`endif

    // Reset asserted while waiting for the engine to finish a frame.
    pulse_load();
    n = 0;
    while (!(ser_busy && !ser_start && busy) && n < 200) begin @(negedge clk); n++; end
    check("mr_in_wait_lo", 64'(ser_busy && !ser_start && busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mr_outputs", 64'({host_ack, host_rdata, ser_start, ser_rw, ser_addr, ser_wdata,
                             busy, cfg_done, cfg_err, err_mask}), 64'(0));
    n = 0;
    while (ser_busy && n < 100) begin @(negedge clk); n++; end
    check("mr_engine_done", 64'(ser_busy), 64'(0));
    @(negedge clk);
    nf = frames.size();
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_restart_busy", 64'(busy), 64'(1));
    wait_idle("mr_idle");
    check("mr_frames", 64'(frames.size() - nf), 64'(8 * FPB));
    check_frame("mr_a0", nf, 1'b1, 3'd0, 9'h010);
    check_frame("mr_a2", nf + 2 * FPB, 1'b1, 3'd2, 9'h012);
    check_frame("mr_a6", nf + 6 * FPB, 1'b1, 3'd6, 9'h016);
    check("mr_done", 64'(cfg_done), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_cfg_sequencer.md
# adc_cfg_sequencer

Configuration controller for the CCD front-end ADC's 3-bit-address / 9-bit-data serial register port. Holds an 8-entry shadow copy of the ADC register file, loads it into the ADC after reset or on command, and shares the serial engine between that batch load and single host accesses. It sits between the host/control logic and the serial shift engine that drives sdata/sclk/sload.

## Interface
- `DEFAULT_CFG`, 72'h0, reset contents of the shadow file; entry n occupies bits [9n+8:9n].
- `AUTO_LOAD`, 1, when 1 a batch load starts automatically after reset release.
- `TIMEOUT`, 4096, clk cycles allowed per wait state before abort (≥2).
- `clk` in 1 system clock.
- `rst_n` in 1 asynchronous active-low reset.
- `shd_we` in 1 shadow write strobe.
- `shd_addr` in 3 shadow entry index.
- `shd_wdata` in 9 shadow write data.
- `cfg_load` in 1 one-cycle pulse, request a batch load.
- `host_req` in 1 single-access request, level, held until `host_ack`.
- `host_rw` in 1 1 = write, 0 = read.
- `host_addr` in 3 ADC register address.
- `host_wdata` in 9 write data.
- `host_ack` out 1 one-cycle completion pulse.
- `host_rdata` out 9 read data, valid with `host_ack` and held afterwards.
- `ser_start` out 1 transaction request to the serial engine (level).
- `ser_rw` out 1 direction to the engine.
- `ser_addr` out 3 address to the engine.
- `ser_wdata` out 9 write data to the engine.
- `ser_busy` in 1 engine busy; already synchronised to `clk`.
- `ser_rdata` in 9 engine read result, valid when `ser_busy` falls.
- `busy` out 1 controller not idle.
- `cfg_done` out 1 last batch completed without error (sticky until the next batch starts).
- `cfg_err` out 1 last batch aborted or mismatched (sticky until the next batch starts).
- `err_mask` out 8 per-entry readback mismatch flags.

## Operation
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, NEXT; VERIFY is added under the macro.
- IDLE → ISSUE. A batch is pending if `cfg_load` was seen, or if `AUTO_LOAD` is set and this is the first cycle after reset. Batch wins over `host_req` when both are present.
- A host request is served only from IDLE. It is never interleaved inside a batch and waits until the batch ends.
- Batch order: index 0..7. Each transaction drives `ser_rw`=1, `ser_addr`=index and `ser_wdata`=shadow[index].
- ISSUE: assert `ser_start`, then go to WAIT_HI.
- WAIT_HI: hold `ser_start` and the `ser_*` fields until `ser_busy`=1. Then drop `ser_start` and go to WAIT_LO.
- WAIT_LO: wait for `ser_busy`=0, then go to NEXT (or VERIFY).
- NEXT: after index 7, set `cfg_done`=1 and return to IDLE. Otherwise increment the index and go to ISSUE.
- Host transaction: one ISSUE/WAIT_HI/WAIT_LO pass, then `host_ack` pulses.
  - A host write also updates shadow[`host_addr`].
  - A host read latches `ser_rdata` into `host_rdata`.
- Timeout: the counter reloads on each entry to WAIT_HI/WAIT_LO. Expiry →
  - deassert `ser_start`, return to IDLE;
  - for a batch: `cfg_err`=1, `cfg_done`=0;
  - for a host access: `host_ack` still pulses and `host_rdata` = 9'h1FF.
- Batch start clears `cfg_done`, `cfg_err` and `err_mask`.
- `shd_we` writes the shadow file in any state. If it hits an entry already sent in the current batch, that entry is not resent.
- A `cfg_load` arriving during a batch is recorded once; one extra batch runs afterwards.

## Timing
- Reset values:
  - all outputs 0;
  - shadow = `DEFAULT_CFG`;
  - state IDLE;
  - batch-pending flag = `AUTO_LOAD`.
- Latency: the `ser_*` outputs are registered. `ser_start` rises 2 clk after `cfg_load` or `host_req` is sampled in IDLE.
- `host_ack` comes 1 clk after `ser_busy` is sampled low in WAIT_LO.
- `busy` is high from the cycle after acceptance through the cycle of `host_ack` or of the final NEXT.
- `rst_n` asserted mid-transaction: immediate return to reset values. `ser_start` falls asynchronously, and the engine is expected to finish its frame on its own.

## Configuration
- `ADC_CFG_READBACK_EN` defined:
  - after each batch write, VERIFY issues a read (`ser_rw`=0) of the same address through ISSUE/WAIT_HI/WAIT_LO;
  - if `ser_rdata` ≠ shadow[index], set `err_mask[index]` and `cfg_err`, then continue to the next entry;
  - `cfg_done` is set only if `err_mask`==0 at the end of the batch.
- Undefined: no VERIFY state; `err_mask` is tied to 0; `cfg_err` is set only on timeout.

## Test plan
- Reset release with `AUTO_LOAD`=1 and `DEFAULT_CFG` entry n = 9'h010+n, engine model busy for 20 clk → 8 writes at addresses 0..7 with data 0x010..0x017, then `cfg_done`=1 and `busy`=0.
- `host_req` read of addr 5 with the model returning 9'h0AB → exactly one read frame; `host_ack` pulse with `host_rdata`=9'h0AB.
- `host_req` write of addr 2 = 9'h155 issued during a batch → the write goes out only after index 7. Then shadow[2]=9'h155, and the next `cfg_load` sends 9'h155 to addr 2.
- Engine never raises `ser_busy`, `TIMEOUT`=16 → `ser_start` falls after 16 clk in WAIT_HI; `cfg_err`=1, `cfg_done`=0, state IDLE.
- With macro defined, model corrupts the readback of addr 3 → `err_mask`=8'h08, `cfg_err`=1, `cfg_done`=0; all 16 frames are still issued.
- `rst_n` pulsed low while in WAIT_LO → all outputs 0 on the same edge; a new `AUTO_LOAD` batch starts from index 0 after release.
